// File: rtl/pipe_stage_reg_if.sv
// Valid/ready word-set channel between Bellman-Ford pipeline stages.
// Word set is NUM_CH words of WORD_SIZE bits; channel k sits at [k*WORD_SIZE +: WORD_SIZE].
interface pipe_stage_reg_if #(
  parameter int WORD_SIZE = 8,
  parameter int NUM_CH    = 4
);
  logic                        valid;
  logic                        ready;
  logic [NUM_CH*WORD_SIZE-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready backpressure, sync flush and saturating stall counter.
// Define PIPE_REG_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
  parameter int WORD_SIZE = 8,
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 clear_n,
  input  logic                 flush,
  pipe_stage_reg_if.slave      in_bus,
  pipe_stage_reg_if.master     out_bus,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  typedef logic [NUM_CH-1:0][WORD_SIZE-1:0] word_set_t;
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t    state;
  logic      out_valid;
  logic      in_ready;
  logic      in_xfer;
  logic      out_xfer;
  logic      ld_main;
  word_set_t in_word;
  word_set_t out_word;

  assign in_word  = in_bus.data;
  assign in_xfer  = in_bus.valid && in_ready;
  assign out_xfer = out_valid && out_bus.ready;

`ifdef PIPE_REG_SKID_EN
  logic ld_skid;
  logic sel_skid;

  // Main reloads from input on EMPTY/BUSY, from skid when FULL drains.
  assign ld_main  = ((state == EMPTY) && in_xfer) ||
                    ((state == BUSY) && in_xfer && out_xfer) ||
                    ((state == FULL) && out_xfer);
  assign ld_skid  = (state == BUSY) && in_xfer && !out_xfer;
  assign sel_skid = (state == FULL);
`else
  // Without a skid entry we may only accept when main is free or draining now.
  assign in_ready = !out_valid || out_bus.ready;
  assign ld_main  = in_xfer;
`endif

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
`ifdef PIPE_REG_SKID_EN
      in_ready  <= 1'b1;
`endif
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
`ifdef PIPE_REG_SKID_EN
      in_ready  <= 1'b1;
`endif
    end else begin
      case (state)
        EMPTY: if (in_xfer) begin
          state     <= BUSY;
          out_valid <= 1'b1;
        end
        BUSY: if (out_xfer && !in_xfer) begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
`ifdef PIPE_REG_SKID_EN
        else if (in_xfer && !out_xfer) begin
          state    <= FULL;
          in_ready <= 1'b0;
        end
        FULL: if (out_xfer) begin
          state    <= BUSY;
          in_ready <= 1'b1;
        end
`endif
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
`ifdef PIPE_REG_SKID_EN
          in_ready  <= 1'b1;
`endif
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [WORD_SIZE-1:0] main_r;
`ifdef PIPE_REG_SKID_EN
    logic [WORD_SIZE-1:0] skid_r;

    always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n)     skid_r <= '0;
      else if (flush)   skid_r <= '0;
      else if (ld_skid) skid_r <= in_word[k];
    end

    always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n)     main_r <= '0;
      else if (flush)   main_r <= '0;
      else if (ld_main) main_r <= sel_skid ? skid_r : in_word[k];
    end
`else
    always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n)     main_r <= '0;
      else if (flush)   main_r <= '0;
      else if (ld_main) main_r <= in_word[k];
    end
`endif
    assign out_word[k] = main_r;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)
      stall_cnt <= '0;
    else if (flush)
      stall_cnt <= '0;
    else if (out_valid && !out_bus.ready && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_WIDTH'(1);
  end

  assign in_bus.ready  = in_ready;
  assign out_bus.valid = out_valid;
  assign out_bus.data  = out_word;

endmodule
